// File: rtl/spi_flash_rd_pkg.sv
// Shared definitions for the SPI flash read sequencer: controller register map,
// CTRL bit positions, flash opcode, FSM state type and word-building helpers.
package spi_flash_rd_pkg;

    localparam logic [7:0] REG_CTRL       = 8'h00;
    localparam logic [7:0] REG_DATA       = 8'h04;
    localparam logic [7:0] REG_STATUS     = 8'h08;

    localparam int         CTRL_START     = 0;
    localparam int         CTRL_CPOL      = 1;
    localparam int         CTRL_CPHA      = 2;
    localparam int         CTRL_SS        = 3;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam logic [3:0] SEL_WORD       = 4'hF;
    localparam logic [7:0] DUMMY_BYTE     = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CS_ON    = 4'd1,
        ST_LOAD     = 4'd2,
        ST_GO       = 4'd3,
        ST_ARM      = 4'd4,
        ST_POLL_RD  = 4'd5,
        ST_POLL_CHK = 4'd6,
        ST_DAT_RD   = 4'd7,
        ST_CAPT     = 4'd8,
        ST_OUT      = 4'd9,
        ST_CS_OFF   = 4'd10,
        ST_FIN      = 4'd11
    } state_e;

    // CTRL word in SPI mode 0 with the given divider, slave-select and start bits.
    function automatic logic [31:0] ctrl_word(input logic [7:0] div,
                                              input logic       ss,
                                              input logic       go);
        logic [7:0] low;
        low             = 8'h00;
        low[CTRL_START] = go;
        low[CTRL_CPOL]  = 1'b0;
        low[CTRL_CPHA]  = 1'b0;
        low[CTRL_SS]    = ss;
        return {16'h0000, div, low};
    endfunction

    // Byte shifted out for a given position: opcode, three address bytes, then dummies.
    function automatic logic [7:0] tx_byte(input logic [16:0] idx,
                                           input logic [23:0] addr);
        logic [7:0] b;
        case (idx)
            17'd0:   b = FLASH_CMD_READ;
            17'd1:   b = addr[23:16];
            17'd2:   b = addr[15:8];
            17'd3:   b = addr[7:0];
            default: b = DUMMY_BYTE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_flash_rd.sv
// Flash read sequencer: drives a register-mapped SPI controller to issue a 0x03 read
// and streams the returned bytes out over a valid/ready handshake.
module spi_flash_rd
    import spi_flash_rd_pkg::*;
#(
    parameter int unsigned POLL_GAP = 3
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [23:0] addr_i,
    input  logic [15:0] len_i,
    input  logic [7:0]  div_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  rdata_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [7:0]  spi_waddr_o,
    output logic [31:0] spi_data_o,
    output logic [3:0]  spi_sel_o,
    output logic        spi_we_o,
    output logic [7:0]  spi_raddr_o,
    output logic        spi_rd_o,
    input  logic [31:0] spi_data_i
);

    localparam logic [15:0] GAP_LAST = 16'((POLL_GAP == 0) ? 0 : (POLL_GAP - 1));

    state_e      state_r;
    state_e      state_nxt_s;
    logic [23:0] addr_r;
    logic [15:0] len_r;
    logic [7:0]  div_r;
    logic [16:0] byte_idx_r;
    logic [16:0] idx_nxt_s;
    logic [15:0] gap_cnt_r;
    logic [7:0]  div_use_s;
    logic        last_data_s;

    logic        busy_r;
    logic        done_r;
    logic [7:0]  rdata_r;
    logic        rvalid_r;
    logic [7:0]  waddr_r;
    logic [31:0] wdata_r;
    logic [3:0]  sel_r;
    logic        we_r;
    logic [7:0]  raddr_r;
    logic        rd_r;

    // The CS_ON write happens on the same edge the inputs are latched, so use div_i there.
    assign div_use_s   = (state_r == ST_IDLE) ? div_i : div_r;
    // Data bytes occupy byte_idx 4 .. len+3; 17 bits keep len=16'hFFFF from wrapping.
    assign last_data_s = (byte_idx_r == ({1'b0, len_r} + 17'd3));

    // Next-state and byte-index selection.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = byte_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt_s = ST_CS_ON;
                    idx_nxt_s   = 17'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CS_ON:   state_nxt_s = ST_LOAD;
            ST_LOAD:    state_nxt_s = ST_GO;
            ST_GO: begin
                if (POLL_GAP == 0) begin
                    state_nxt_s = ST_POLL_RD;
                end else begin
                    state_nxt_s = ST_ARM;
                end
            end
            ST_ARM: begin
                if (gap_cnt_r >= GAP_LAST) begin
                    state_nxt_s = ST_POLL_RD;
                end else begin
                    state_nxt_s = ST_ARM;
                end
            end
            ST_POLL_RD: state_nxt_s = ST_POLL_CHK;
            ST_POLL_CHK: begin
                if (spi_data_i[0]) begin
                    state_nxt_s = ST_POLL_RD;
                end else if (byte_idx_r < 17'd4) begin
                    if ((byte_idx_r == 17'd3) && (len_r == 16'd0)) begin
                        state_nxt_s = ST_CS_OFF;
                    end else begin
                        state_nxt_s = ST_LOAD;
                        idx_nxt_s   = byte_idx_r + 17'd1;
                    end
                end else begin
                    state_nxt_s = ST_DAT_RD;
                end
            end
            ST_DAT_RD:  state_nxt_s = ST_CAPT;
            ST_CAPT:    state_nxt_s = ST_OUT;
            ST_OUT: begin
                if (rvalid_r && rready_i) begin
                    if (last_data_s) begin
                        state_nxt_s = ST_CS_OFF;
                    end else begin
                        state_nxt_s = ST_LOAD;
                        idx_nxt_s   = byte_idx_r + 17'd1;
                    end
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            ST_CS_OFF:  state_nxt_s = ST_FIN;
            ST_FIN:     state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state, latched request and registered outputs; bus strobes are decoded from
    // the entered state so a read strobe's data lands in the following state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            addr_r     <= 24'd0;
            len_r      <= 16'd0;
            div_r      <= 8'd0;
            byte_idx_r <= 17'd0;
            gap_cnt_r  <= 16'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rdata_r    <= 8'd0;
            rvalid_r   <= 1'b0;
            waddr_r    <= 8'd0;
            wdata_r    <= 32'd0;
            sel_r      <= 4'd0;
            we_r       <= 1'b0;
            raddr_r    <= 8'd0;
            rd_r       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            byte_idx_r <= idx_nxt_s;
            if ((state_r == ST_IDLE) && start_i) begin
                addr_r <= addr_i;
                len_r  <= len_i;
                div_r  <= div_i;
            end
            gap_cnt_r <= (state_r == ST_ARM) ? (gap_cnt_r + 16'd1) : 16'd0;
            busy_r    <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_FIN);
            done_r    <= (state_nxt_s == ST_FIN);

            we_r    <= 1'b0;
            waddr_r <= 8'd0;
            wdata_r <= 32'd0;
            sel_r   <= 4'd0;
            rd_r    <= 1'b0;
            raddr_r <= 8'd0;
            case (state_nxt_s)
                ST_CS_ON: begin
                    we_r    <= 1'b1;
                    waddr_r <= REG_CTRL;
                    wdata_r <= ctrl_word(div_use_s, 1'b1, 1'b0);
                    sel_r   <= SEL_WORD;
                end
                ST_LOAD: begin
                    we_r    <= 1'b1;
                    waddr_r <= REG_DATA;
                    wdata_r <= {24'd0, tx_byte(idx_nxt_s, addr_r)};
                    sel_r   <= SEL_WORD;
                end
                ST_GO: begin
                    we_r    <= 1'b1;
                    waddr_r <= REG_CTRL;
                    wdata_r <= ctrl_word(div_r, 1'b1, 1'b1);
                    sel_r   <= SEL_WORD;
                end
                ST_CS_OFF: begin
                    we_r    <= 1'b1;
                    waddr_r <= REG_CTRL;
                    wdata_r <= ctrl_word(div_r, 1'b0, 1'b0);
                    sel_r   <= SEL_WORD;
                end
                ST_POLL_RD: begin
                    rd_r    <= 1'b1;
                    raddr_r <= REG_STATUS;
                end
                ST_DAT_RD: begin
                    rd_r    <= 1'b1;
                    raddr_r <= REG_DATA;
                end
                default: begin
                    we_r <= 1'b0;
                    rd_r <= 1'b0;
                end
            endcase

            if (state_r == ST_CAPT) begin
                rdata_r  <= spi_data_i[7:0];
                rvalid_r <= 1'b1;
            end else if ((state_r == ST_OUT) && rready_i) begin
                rvalid_r <= 1'b0;
            end else begin
                rvalid_r <= rvalid_r;
            end
        end
    end

    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign rdata_o     = rdata_r;
    assign rvalid_o    = rvalid_r;
    assign spi_waddr_o = waddr_r;
    assign spi_data_o  = wdata_r;
    assign spi_sel_o   = sel_r;
    assign spi_we_o    = we_r;
    assign spi_raddr_o = raddr_r;
    assign spi_rd_o    = rd_r;

endmodule

// File: tb/tb_spi_flash_rd.sv
// Bench for spi_flash_rd: behavioural SPI controller plus a transaction-level
// scoreboard of expected register writes and output bytes.
module tb_spi_flash_rd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [23:0] addr_i;
    logic [15:0] len_i;
    logic [7:0]  div_i;
    logic        busy_o, done_o, rvalid_o, rready_i;
    logic [7:0]  rdata_o;
    logic [7:0]  spi_waddr_o, spi_raddr_o;
    logic [31:0] spi_data_o, spi_data_i;
    logic [3:0]  spi_sel_o;
    logic        spi_we_o, spi_rd_o;

    always #5 clk = ~clk;

    spi_flash_rd #(.POLL_GAP(3)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
        .div_i(div_i), .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .spi_waddr_o(spi_waddr_o),
        .spi_data_o(spi_data_o), .spi_sel_o(spi_sel_o), .spi_we_o(spi_we_o),
        .spi_raddr_o(spi_raddr_o), .spi_rd_o(spi_rd_o), .spi_data_i(spi_data_i)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // SPI controller model: status busy appears 2 edges after a start write, lasts 16*(div+1).
    logic [7:0]  rx_tbl [16];
    logic        ctl_busy;
    int          ctl_cnt, ctl_lag, ctl_ntx, busy_polls;
    logic [7:0]  ctl_div;
    logic [31:0] ctl_rdata;
    assign spi_data_i = ctl_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_busy <= 1'b0; ctl_cnt <= 0; ctl_lag <= 0; ctl_ntx <= 0;
            ctl_div <= 8'd0; ctl_rdata <= 32'd0;
        end else begin
            if (spi_we_o && spi_waddr_o == 8'h00 && spi_data_o[0]) begin
                ctl_lag <= 2;
                ctl_div <= spi_data_o[15:8];
            end else if (ctl_lag == 2) begin
                ctl_lag <= 1;
            end else if (ctl_lag == 1) begin
                ctl_lag  <= 0;
                ctl_busy <= 1'b1;
                ctl_cnt  <= 16 * (int'(ctl_div) + 1);
            end else if (ctl_busy) begin
                if (ctl_cnt <= 1) ctl_busy <= 1'b0;
                ctl_cnt <= ctl_cnt - 1;
            end
            if (spi_we_o && spi_waddr_o == 8'h00 && spi_data_o[3] && !spi_data_o[0])
                ctl_ntx <= 0;
            else if (spi_we_o && spi_waddr_o == 8'h04)
                ctl_ntx <= ctl_ntx + 1;
            if (spi_rd_o) begin
                if (spi_raddr_o == 8'h08) begin
                    ctl_rdata <= {31'd0, ctl_busy};
                    if (ctl_busy) busy_polls <= busy_polls + 1;
                end else if (spi_raddr_o == 8'h04) begin
                    ctl_rdata <= {24'd0, rx_tbl[(ctl_ntx + 15) % 16]};
                end else begin
                    ctl_rdata <= 32'd0;
                end
            end
        end
    end

    // Scoreboard queues and per-run logs.
    logic [7:0]  exp_wa [$];
    logic [31:0] exp_wd [$];
    logic [7:0]  exp_rx [$];
    logic [7:0]  dlog [$];
    logic [7:0]  slog [$];
    logic [31:0] last_ctrl;
    int          done_cnt = 0, rv_cycles = 0, stall_writes = 0;
    logic        prev_rv, prev_hs;
    logic [7:0]  prev_rd;
    logic [7:0]  mon_wa;
    logic [31:0] mon_wd;
    bit          in_run = 1'b0;

    function automatic logic [7:0] exp_tx(input int i, input logic [23:0] a);
        if (i == 0)      return 8'h03;
        else if (i == 1) return a[23:16];
        else if (i == 2) return a[15:8];
        else if (i == 3) return a[7:0];
        else             return 8'h00;
    endfunction

    // Per-cycle compare against the scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rv = 1'b0; prev_hs = 1'b0; prev_rd = 8'd0;
        end else begin
            chk("we_rd_excl", {31'd0, spi_we_o & spi_rd_o}, 32'd0);
            if (!in_run)
                chk("idle_outputs", {11'd0, spi_we_o, spi_rd_o, busy_o, done_o, rvalid_o,
                                     spi_waddr_o, spi_raddr_o}, 32'd0);
            else if (done_o)
                chk("busy_at_done", {31'd0, busy_o}, 32'd0);
            else
                chk("busy_in_run", {31'd0, busy_o}, 32'd1);
            if (spi_we_o) begin
                if (exp_wa.size() == 0) begin
                    chk("extra_write", spi_data_o, 32'hDEAD_0000);
                end else begin
                    mon_wa = exp_wa.pop_front();
                    mon_wd = exp_wd.pop_front();
                    chk("waddr", {24'd0, spi_waddr_o}, {24'd0, mon_wa});
                    chk("wdata", spi_data_o, mon_wd);
                    chk("wsel", {28'd0, spi_sel_o}, 32'hF);
                end
                if (spi_waddr_o == 8'h04) dlog.push_back(spi_data_o[7:0]);
                if (spi_waddr_o == 8'h00) last_ctrl = spi_data_o;
            end
            if (rvalid_o) begin
                rv_cycles++;
                if (spi_we_o) stall_writes++;
                chk("rd_while_valid", {31'd0, spi_rd_o}, 32'd0);
            end
            if (prev_rv && !prev_hs) begin
                chk("rvalid_hold", {31'd0, rvalid_o}, 32'd1);
                chk("rdata_hold", {24'd0, rdata_o}, {24'd0, prev_rd});
            end
            if (rvalid_o && rready_i) begin
                if (exp_rx.size() == 0) chk("extra_byte", {24'd0, rdata_o}, 32'hDEAD_0001);
                else chk("rdata", {24'd0, rdata_o}, {24'd0, exp_rx.pop_front()});
                slog.push_back(rdata_o);
            end
            if (done_o) begin
                done_cnt++;
                chk("done_in_run", {31'd0, in_run}, 32'd1);
                chk("writes_left", 32'(exp_wa.size()), 32'd0);
                chk("bytes_left", 32'(exp_rx.size()), 32'd0);
            end
            prev_rv = rvalid_o;
            prev_hs = rvalid_o && rready_i;
            prev_rd = rdata_o;
        end
    end

    task automatic start_seq(input logic [23:0] a, input logic [15:0] l, input logic [7:0] d);
        exp_wa.push_back(8'h00); exp_wd.push_back({16'h0, d, 8'h08});
        for (int i = 0; i < int'(l) + 4; i++) begin
            exp_wa.push_back(8'h04); exp_wd.push_back({24'h0, exp_tx(i, a)});
            exp_wa.push_back(8'h00); exp_wd.push_back({16'h0, d, 8'h09});
            if (i >= 4) exp_rx.push_back(rx_tbl[i % 16]);
        end
        exp_wa.push_back(8'h00); exp_wd.push_back({16'h0, d, 8'h00});
        dlog.delete(); slog.delete();
        addr_i = a; len_i = l; div_i = d; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; in_run = 1'b1;
        addr_i = ~a; len_i = ~l; div_i = ~d;
    endtask

    task automatic flush_model();
        exp_wa.delete(); exp_wd.delete(); exp_rx.delete();
    endtask

    task automatic wait_done(input string tag);
        int  d0;
        bit  ok;
        d0 = done_cnt;
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            if (done_cnt != d0) begin ok = 1'b1; break; end
        end
        chk({tag, "_done_timeout"}, {31'd0, ok}, 32'd1);
        in_run = 1'b0;
        #1;
        if (!ok) begin
            rst_n = 1'b0; flush_model(); #10; rst_n = 1'b1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl_zero"}, {8'd0, busy_o, done_o, rvalid_o, spi_we_o, spi_rd_o, 3'd0,
                                 rdata_o, spi_waddr_o}, 32'd0);
        chk({tag, "_bus_zero"}, spi_data_o | {16'd0, spi_raddr_o, 4'd0, spi_sel_o}, 32'd0);
    endtask

    logic [7:0] exp_dlog1 [6];
    int         d_snap, rv_snap, st_snap, bp_snap;
    bit         found;

    initial begin
        exp_dlog1 = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00};
        for (int i = 0; i < 16; i++) rx_tbl[i] = 8'(i * 29 + 7);
        busy_polls = 0;
        rst_n = 1'b0; start_i = 1'b0; addr_i = 24'd0; len_i = 16'd0; div_i = 8'd0;
        rready_i = 1'b1;
        #1 chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic read, 2 bytes
        rx_tbl[4] = 8'hA5; rx_tbl[5] = 8'h5A;
        d_snap = done_cnt;
        start_seq(24'h012345, 16'd2, 8'h00);
        wait_done("t1");
        chk("t1_dlog_len", 32'(dlog.size()), 32'd6);
        if (dlog.size() == 6)
            for (int i = 0; i < 6; i++) chk("t1_dlog", {24'd0, dlog[i]}, {24'd0, exp_dlog1[i]});
        chk("t1_stream_len", 32'(slog.size()), 32'd2);
        if (slog.size() == 2) begin
            chk("t1_byte0", {24'd0, slog[0]}, 32'hA5);
            chk("t1_byte1", {24'd0, slog[1]}, 32'h5A);
        end
        chk("t1_last_ctrl", last_ctrl, 32'h0000_0000);
        chk("t1_done_cnt", 32'(done_cnt - d_snap), 32'd1);
        for (int i = 0; i < 16; i++) rx_tbl[i] = 8'(i * 29 + 7);

        // Zero-length read
        d_snap = done_cnt; rv_snap = rv_cycles;
        start_seq(24'hABCDEF, 16'd0, 8'h00);
        wait_done("t2");
        chk("t2_data_writes", 32'(dlog.size()), 32'd4);
        chk("t2_rvalid_cycles", 32'(rv_cycles - rv_snap), 32'd0);
        chk("t2_done_cnt", 32'(done_cnt - d_snap), 32'd1);

        // Back-pressure on the first byte
        rv_snap = rv_cycles; st_snap = stall_writes;
        start_seq(24'h102030, 16'd3, 8'h00);
        rready_i = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (rvalid_o) begin found = 1'b1; break; end
        end
        chk("t3_rvalid_seen", {31'd0, found}, 32'd1);
        repeat (20) @(posedge clk);
        #1 rready_i = 1'b1;
        wait_done("t3");
        chk("t3_writes_in_stall", 32'(stall_writes - st_snap), 32'd0);
        chk("t3_stall_long", {31'd0, (rv_cycles - rv_snap) >= 20}, 32'd1);

        // Start pulsed while busy is ignored
        start_seq(24'h00FF00, 16'd2, 8'h00);
        repeat (25) @(posedge clk);
        #1 addr_i = 24'hFFFFFF; len_i = 16'd5; div_i = 8'h07; start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        wait_done("t4");
        chk("t4_dlog_len", 32'(dlog.size()), 32'd6);
        if (dlog.size() == 6) chk("t4_addr", {8'd0, dlog[1], dlog[2], dlog[3]}, 32'h0000FF00);

        // Slow divider, polling must loop
        bp_snap = busy_polls;
        start_seq(24'h0A0B0C, 16'd2, 8'h03);
        wait_done("t5");
        chk("t5_busy_polled", {31'd0, busy_polls > bp_snap}, 32'd1);
        chk("t5_last_ctrl", last_ctrl, 32'h0000_0300);

        // Reset while checking status, then a clean 1-byte read
        start_seq(24'h111111, 16'd4, 8'h00);
        found = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            if (spi_rd_o && spi_raddr_o == 8'h08) begin found = 1'b1; break; end
        end
        chk("t6_status_read_seen", {31'd0, found}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0; in_run = 1'b0; flush_model();
        #1 chk_reset_outputs("t6_rst");
        @(posedge clk); #1 chk_reset_outputs("t6_rst_edge");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        d_snap = done_cnt;
        start_seq(24'h445566, 16'd1, 8'h00);
        wait_done("t6");
        chk("t6_stream_len", 32'(slog.size()), 32'd1);
        if (slog.size() == 1) chk("t6_byte0", {24'd0, slog[0]}, 32'h7B);
        chk("t6_done_cnt", 32'(done_cnt - d_snap), 32'd1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
